unified_mem_fetch_arbiter: RTL and testbench

//  Parametrised single-port memory front end for the pipelined RV32 core. Arbitrates one shared

---
 rtl/rv_core_pkg.sv | 17 +
 rtl/fetch_queue.sv | 71 +++++++
 rtl/unified_mem_fetch_arbiter.sv | 165 ++++++++++++++++
 tb/tb_unified_mem_fetch_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared definitions for the RV32 core front end.
//   NOP_INST  : canonical ADD x0,x0,x0 encoding, shown on ifq_inst while the queue is empty
//   FUNCT3_LW : word-access size code, used on the memory port for every instruction fetch
//   RV_XLEN   : default datapath / PC width
//   ifq_entry_t : one prefetch-queue entry {pc, inst} at the default width
package rv_core_pkg;

  localparam int          RV_XLEN   = 32;
  localparam logic [31:0] NOP_INST  = 32'h0000_0033;
  localparam logic [2:0]  FUNCT3_LW = 3'b010;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [31:0]        inst;
  } ifq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO between the fetch engine and the ID stage.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : write i_push_data at the tail (accepted when not full, or when full and popping)
//   i_push_data  : entry to store
//   i_pop        : drop the head entry (ignored when empty)
//   i_flush      : discard all entries; dominates a simultaneous push or pop
//   o_head       : head entry (contents undefined while !o_valid)
//   o_valid      : queue not empty
//   o_full       : queue holds DEPTH entries
//   o_count      : number of entries held
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_queue #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [W-1:0]  o_head,
  output logic          o_valid,
  output logic          o_full,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_valid   = (r_count != '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && o_valid;
  // When full, a push is only taken if the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/unified_mem_fetch_arbiter.sv
// Single-port memory front end for the pipelined RV32 core. Shares one synchronous memory between
// instruction fetch and MEM-stage loads/stores (data always wins), buffers fetched instructions in
// a DEPTH-entry prefetch queue and flushes it on branch/jump redirect.
// Optional feature macro: IFQ_PERF_EN adds perf_steal_cnt / perf_flush_cnt outputs.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   redirect_valid, redirect_pc    : taken branch/jump; flush queue and restart fetch at redirect_pc&~3
//   ifq_valid/ifq_inst/ifq_pc      : queue head towards ID (inst=NOP, pc=0 when empty)
//   ifq_ready                      : ID accepts head
//   dmem_req/we/addr/wdata/funct3  : MEM-stage access request
//   dmem_gnt                       : request granted this cycle (always equals dmem_req)
//   dmem_rvalid/dmem_rdata         : load return, one cycle after grant
//   mem_addr/we/wdata/funct3       : shared memory port (word address)
//   mem_rdata                      : memory read data, one-cycle latency
//   perf_steal_cnt (IFQ_PERF_EN)   : cycles data took the port while fetch was eligible
//   perf_flush_cnt (IFQ_PERF_EN)   : stale in-flight fetch responses discarded
module unified_mem_fetch_arbiter
  import rv_core_pkg::*;
#(
  parameter int              XLEN     = RV_XLEN,
  parameter int              ADDR_W   = 6,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              ifq_valid,
  output logic [31:0]       ifq_inst,
  output logic [XLEN-1:0]   ifq_pc,
  input  logic              ifq_ready,
  input  logic              dmem_req,
  input  logic              dmem_we,
  input  logic [XLEN-1:0]   dmem_addr,
  input  logic [XLEN-1:0]   dmem_wdata,
  input  logic [2:0]        dmem_funct3,
  output logic              dmem_gnt,
  output logic              dmem_rvalid,
  output logic [XLEN-1:0]   dmem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [2:0]        mem_funct3,
`ifdef IFQ_PERF_EN
  output logic [31:0]       perf_steal_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + 32;

  logic [XLEN-1:0] r_fetch_pc;
  logic            r_epoch;
  logic            r_fetch_vld_p1;
  logic            r_fetch_epoch_p1;
  logic [XLEN-1:0] r_fetch_pc_p1;
  logic            r_load_vld_p1;

  logic [CW:0]     w_occ;
  logic            w_fetch_elig;
  logic            w_fetch_issue;
  logic            w_push;
  logic            w_pop;
  logic [EW-1:0]   w_push_data;
  logic [EW-1:0]   w_head;
  logic            w_q_valid;
  logic            w_q_full;
  logic [CW-1:0]   w_q_count;
  logic            w_unused_addr_bits;

  // Bits of the byte address that do not select a memory word.
  assign w_unused_addr_bits = ^{dmem_addr[XLEN-1:ADDR_W+2], dmem_addr[1:0]};

  // ---- p0: arbitration and issue ----
  // Occupancy counts entries held plus the response still on its way back, using registered
  // values only; a pop in this same cycle does not open a slot until next cycle.
  assign w_occ         = {1'b0, w_q_count} + (CW+1)'(r_fetch_vld_p1);
  assign w_fetch_elig  = (w_occ < (CW+1)'(DEPTH)) && !w_q_full;
  assign w_fetch_issue = !dmem_req && w_fetch_elig;

  assign dmem_gnt   = dmem_req;
  assign mem_addr   = dmem_req ? dmem_addr[ADDR_W+1:2] : r_fetch_pc[ADDR_W+1:2];
  assign mem_we     = dmem_req && dmem_we;
  assign mem_wdata  = dmem_wdata;
  assign mem_funct3 = dmem_req ? dmem_funct3 : FUNCT3_LW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc       <= RESET_PC;
      r_epoch          <= 1'b0;
      r_fetch_vld_p1   <= 1'b0;
      r_fetch_epoch_p1 <= 1'b0;
      r_load_vld_p1    <= 1'b0;
    end else begin
      r_fetch_vld_p1   <= w_fetch_issue;
      r_fetch_epoch_p1 <= r_epoch;
      r_load_vld_p1    <= dmem_req && !dmem_we;
      // A fetch issued in a redirect cycle still uses the old PC; it carries the old epoch and
      // is discarded on return. The most recent redirect always sets the PC.
      if (redirect_valid) begin
        r_epoch    <= ~r_epoch;
        r_fetch_pc <= redirect_pc & ~XLEN'(3);
      end else if (w_fetch_issue) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fetch_issue) r_fetch_pc_p1 <= r_fetch_pc;
  end

  // ---- p1: memory response ----
  // Only responses from the current epoch enter the queue; a redirect in this cycle also
  // flushes, which dominates inside the queue.
  assign w_push      = r_fetch_vld_p1 && (r_fetch_epoch_p1 == r_epoch);
  assign w_push_data = {r_fetch_pc_p1, mem_rdata[31:0]};
  assign w_pop       = ifq_ready;

  assign dmem_rvalid = r_load_vld_p1;
  assign dmem_rdata  = r_load_vld_p1 ? mem_rdata : '0;

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fetch_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_valid     (w_q_valid),
    .o_full      (w_q_full),
    .o_count     (w_q_count)
  );

  // ---- p2: queue head towards ID ----
  assign ifq_valid = w_q_valid;
  assign ifq_inst  = w_q_valid ? w_head[31:0]    : NOP_INST;
  assign ifq_pc    = w_q_valid ? w_head[EW-1:32] : '0;

`ifdef IFQ_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_steal_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (dmem_req && w_fetch_elig)
        perf_steal_cnt <= sat_inc(perf_steal_cnt);
      if (r_fetch_vld_p1 && (r_fetch_epoch_p1 != r_epoch))
        perf_flush_cnt <= sat_inc(perf_flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_fetch_arbiter.sv
// Directed bench for unified_mem_fetch_arbiter (XLEN=32, ADDR_W=6, DEPTH=4, RESET_PC=0).
// Memory model: 64 words, mem[i]=i after init, synchronous read with one-cycle latency.
module tb_unified_mem_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifq_valid;
  logic [31:0] ifq_inst;
  logic [31:0] ifq_pc;
  logic        ifq_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [2:0]  dmem_funct3;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [5:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;
`ifdef IFQ_PERF_EN
  logic [31:0] perf_steal_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  logic        init_mem = 1'b1;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  unified_mem_fetch_arbiter #(
    .XLEN     (32),
    .ADDR_W   (6),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifq_valid      (ifq_valid),
    .ifq_inst       (ifq_inst),
    .ifq_pc         (ifq_pc),
    .ifq_ready      (ifq_ready),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_funct3    (dmem_funct3),
    .dmem_gnt       (dmem_gnt),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_funct3     (mem_funct3),
`ifdef IFQ_PERF_EN
    .perf_steal_cnt (perf_steal_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .mem_rdata      (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic head(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, "_valid"}, 32'(ifq_valid), 32'(v));
    chk({tag, "_pc"},    ifq_pc,         pc);
    chk({tag, "_inst"},  ifq_inst,       inst);
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (ifq_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Leaves the bench at a falling edge with rst just released (cycle 0).
  task automatic do_reset(input logic rdy);
    rst            = 1'b1;
    ifq_ready      = rdy;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    dmem_addr      = '0;
    dmem_wdata     = '0;
    dmem_funct3    = 3'b000;
    step();
    head("rst", 1'b0, 32'h0, 32'h0000_0033);
    chk("rst_rvalid", 32'(dmem_rvalid), 32'd0);
    chk("rst_rdata",  dmem_rdata,       32'd0);
    chk("rst_mem_we", 32'(mem_we),      32'd0);
`ifdef IFQ_PERF_EN
    chk("rst_steal", perf_steal_cnt, 32'd0);
    chk("rst_flush", perf_flush_cnt, 32'd0);
`endif
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          nv;
    bit          ok;

    // Test 1: stream from reset with ID always ready.
    do_reset(1'b1);
    init_mem = 1'b0;
    step();
    head("t1_c1", 1'b0, 32'h0, 32'h0000_0033);
    chk("t1_c1_f3", 32'(mem_funct3), 32'd2);
    chk("t1_c1_we", 32'(mem_we),     32'd0);
    step(); head("t1_c2", 1'b1, 32'h0, 32'd0);
    step(); head("t1_c3", 1'b1, 32'h4, 32'd1);
    step(); head("t1_c4", 1'b1, 32'h8, 32'd2);

    // Test 2: ID stalled, queue fills with exactly DEPTH fetches, then resumes without a gap.
    do_reset(1'b0);
    repeat (8) step();
    head("t2_hold", 1'b1, 32'h0, 32'd0);
    ifq_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      head("t2_seq", 1'b1, 32'(4 * i), 32'(i));
    end

    // Test 3: load from 0x20 in the middle of the stream.
    exp_pc = 32'd24;
    nv     = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ifq_valid) begin
        chk("t3_pc",   ifq_pc,   exp_pc);
        chk("t3_inst", ifq_inst, exp_pc >> 2);
        exp_pc += 32'd4;
        nv++;
      end
      if (i == 1) begin
        dmem_req    = 1'b1;
        dmem_we     = 1'b0;
        dmem_addr   = 32'h20;
        dmem_funct3 = 3'b100;
        #1;
        chk("t3_gnt",   32'(dmem_gnt),   32'd1);
        chk("t3_addr",  32'(mem_addr),   32'd8);
        chk("t3_we",    32'(mem_we),     32'd0);
        chk("t3_f3",    32'(mem_funct3), 32'd4);
      end
      if (i == 2) begin
        chk("t3_rvalid", 32'(dmem_rvalid), 32'd1);
        chk("t3_rdata",  dmem_rdata,       32'd8);
        dmem_req = 1'b0;
        #1;
        chk("t3_gnt_off", 32'(dmem_gnt), 32'd0);
      end
    end
    chk("t3_nvalid", 32'(nv >= 6), 32'd1);

    // Test 4: redirect with 2 queued and a fetch in flight.
    do_reset(1'b0);
    repeat (3) step();
    head("t4_pre", 1'b1, 32'h0, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    step();
    head("t4_c4", 1'b0, 32'h0, 32'h0000_0033);
    redirect_valid = 1'b0;
    step();
    chk("t4_c5_valid", 32'(ifq_valid), 32'd0);
    step();
    head("t4_c6", 1'b1, 32'h40, 32'd16);
`ifdef IFQ_PERF_EN
    chk("t4_flush_cnt", perf_flush_cnt, 32'd1);
    chk("t4_steal_cnt", perf_steal_cnt, 32'd0);
`endif
    ifq_ready = 1'b1;
    step();
    head("t4_c7", 1'b1, 32'h44, 32'd17);

    // Test 4b: two redirects on consecutive cycles, the second wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    chk("t4b_flushed", 32'(ifq_valid), 32'd0);
    redirect_pc = 32'h90;
    step();
    redirect_valid = 1'b0;
    wait_valid(8, ok);
    chk("t4b_timeout", 32'(ok), 32'd1);
    head("t4b_head", 1'b1, 32'h90, 32'd36);

    // Test 5: store then load of the same word.
    dmem_req    = 1'b1;
    dmem_we     = 1'b1;
    dmem_addr   = 32'h10;
    dmem_wdata  = 32'hDEAD_BEEF;
    dmem_funct3 = 3'b010;
    #1;
    chk("t5_st_gnt",   32'(dmem_gnt), 32'd1);
    chk("t5_st_we",    32'(mem_we),   32'd1);
    chk("t5_st_addr",  32'(mem_addr), 32'd4);
    chk("t5_st_wdata", mem_wdata,     32'hDEAD_BEEF);
    step();
    chk("t5_st_rvalid", 32'(dmem_rvalid), 32'd0);
    dmem_we = 1'b0;
    #1;
    chk("t5_ld_we", 32'(mem_we), 32'd0);
    step();
    chk("t5_ld_rvalid", 32'(dmem_rvalid), 32'd1);
    chk("t5_ld_rdata",  dmem_rdata,       32'hDEAD_BEEF);
    dmem_req = 1'b0;
    step();
    chk("t5_rvalid_off", 32'(dmem_rvalid), 32'd0);
    chk("t5_rdata_off",  dmem_rdata,       32'd0);
`ifdef IFQ_PERF_EN
    chk("t5_steal_cnt", perf_steal_cnt, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
